receive: RTL and testbench
==========================

# receive

PCS receive state machine: the receive-side counterpart of the ordered-set transmit FSM. It consumes decoded code groups from the 10b/8b decoder and the synchronization block. It recognises /I/, /S/, /D/, /T/, /R/ and error groups, and drives the GMII receive signals RXD, RX_DV and RX_ER. It also keeps a saturating count of receive errors.

## Interface
- ERR_CNT_W, 8, width of the saturating error counter.
- GTX_CLK  in  1  single clock; all logic on its rising edge.
- mr_main_reset  in  1  asynchronous, active-low reset.
- sync_status  in  1  1 = code-group alignment acquired.
- rx_octet  in  8  decoded octet of the current code group.
- rx_is_k  in  1  1 = control (K) group, 0 = data (D) group.
- rx_cg_valid  in  1  0 = code group not in decode table, or disparity error.
- RXD  out  8  GMII receive data.
- RX_DV  out  1  GMII receive data valid.
- RX_ER  out  1  GMII receive error.
- receiving  out  1  high while inside a packet, from /S/ through /T/.
- rx_err_count  out  ERR_CNT_W  saturating error count.

## Operation
- Code-group constants:
  - K28.5 = 0xBC (comma)
  - /S/ = K27.7 = 0xFB
  - /T/ = K29.7 = 0xFD
  - /R/ = K23.7 = 0xF7
  - /V/ = K30.7 = 0xFE
  - idle data groups: D5.6 = 0xC5, D16.2 = 0x50
- A group is "data" when rx_is_k=0 and rx_cg_valid=1. It is "invalid" when rx_cg_valid=0.
- Default output values, unless a state below says otherwise: RXD=0x00, RX_DV=0, RX_ER=0, receiving=0.
- States, one-hot:
  - LINK_FAILED: leave only when sync_status=1, then go to WAIT_FOR_K.
  - WAIT_FOR_K: stay until K28.5, then go to RX_K.
  - RX_K: on D5.6 or D16.2 go to IDLE_D. Any other group is an error; go to WAIT_FOR_K.
  - IDLE_D:
    - K28.5 goes to RX_K.
    - /S/ goes to START_OF_PACKET.
    - Anything else is an error; go to WAIT_FOR_K.
  - START_OF_PACKET: outputs RXD=0x55, RX_DV=1, receiving=1. Then evaluated exactly as RECEIVE.
  - RECEIVE (all cases keep receiving=1):
    - data: RXD=rx_octet, RX_DV=1.
    - /T/: go to TRI with RX_DV=0.
    - K28.5 (early end): RX_DV=1, RX_ER=1, RXD=0x00, counts an error; go to RX_K.
    - any other K or invalid group: RX_DV=1, RX_ER=1, RXD=0x00, counts an error; stay in RECEIVE.
  - TRI: /R/ goes to TRR. Anything else is an error; go to WAIT_FOR_K.
  - TRR:
    - /R/ stays in TRR (carrier-extension padding; outputs RX_DV=0, RX_ER=0).
    - K28.5 goes to RX_K.
    - Anything else is an error; go to WAIT_FOR_K.
- Loss of sync: sync_status=0 forces LINK_FAILED from any state.
  - If receiving was 1, the truncation is flagged with one cycle of RX_DV=1, RX_ER=1, RXD=0x00, and one error is counted.
  - Otherwise the outputs go straight to their default values.
- Error counter:
  - Increments by 1 on each error event described above.
  - Saturates at 2^ERR_CNT_W-1 and never wraps.
  - At most one increment per cycle, even when several error conditions coincide.
  - Cleared only by reset.

## Timing
- Reset, asynchronous, mr_main_reset=0:
  - State becomes LINK_FAILED immediately.
  - RXD=0x00, RX_DV=0, RX_ER=0, receiving=0, rx_err_count=0.
  - Release is sampled on the next GTX_CLK edge.
- Reset asserted mid-packet: outputs clear immediately, with no truncation cycle.
- All outputs are registered. A code group presented in cycle n appears on RXD/RX_DV/RX_ER in cycle n+1.
- Latency from input to GMII output is 1 cycle with no bubbles. Back-to-back data groups produce back-to-back RX_DV=1 cycles.
- Packet timing:
  - The /S/ slot maps to one preamble octet 0x55.
  - RX_DV falls in the cycle after /T/ is presented.
  - The shortest legal inter-packet sequence is /T/R/ K28.5 D /S/. A packet may restart in the fifth cycle after /T/.
- sync_status is sampled every cycle and takes priority over every other input.

## Test plan
- Idle lock:
  - Stimulus: reset, sync_status=1, then 4× (K28.5, 0x50).
  - Required: RX_DV=0, RX_ER=0, rx_err_count=0.
  - Then /S/, D 0x11 0x22 0x33, /T/, /R/, K28.5.
  - Required: RX_DV high for 4 cycles with RXD 0x55,0x11,0x22,0x33, starting 1 cycle after /S/. receiving=1 over those cycles.
- Mid-packet invalid group:
  - Stimulus: /S/, 0xAA, rx_cg_valid=0, 0xBB, /T/, /R/.
  - Required: RXD 0x55,0xAA,0x00,0xBB; RX_ER=1 only on the third octet; rx_err_count=1.
- Early end:
  - Stimulus: /S/, 0x01, K28.5, 0xC5.
  - Required: RX_DV=1 and RX_ER=1 in the cycle for K28.5, then idle. rx_err_count=1.
  - A following /S/ is accepted.
- Bad end delimiter:
  - Stimulus: /T/ followed by 0x00 data.
  - Required: error counted, FSM in WAIT_FOR_K; RX_DV stays 0 until the next K28.5, D, /S/ sequence.
- Sync loss and reset:
  - Drop sync_status mid-packet.
  - Required: one cycle of RX_DV=1, RX_ER=1, then all outputs 0.
  - Assert mr_main_reset between clock edges.
  - Required: outputs and counter zero before the next edge.
- Counter saturation:
  - Stimulus: ERR_CNT_W=2 and 5 error events.
  - Required: rx_err_count stops at 3.

Source files
------------

// File: rtl/receive_if.sv
// Receive-side PCS bus: decoded code groups in, GMII receive signals and error count out.
interface receive_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 sync_status;
  logic [7:0]           rx_octet;
  logic                 rx_is_k;
  logic                 rx_cg_valid;
  logic [7:0]           RXD;
  logic                 RX_DV;
  logic                 RX_ER;
  logic                 receiving;
  logic [ERR_CNT_W-1:0] rx_err_count;

  modport master (
    output sync_status, rx_octet, rx_is_k, rx_cg_valid,
    input  RXD, RX_DV, RX_ER, receiving, rx_err_count
  );

  modport slave (
    input  sync_status, rx_octet, rx_is_k, rx_cg_valid,
    output RXD, RX_DV, RX_ER, receiving, rx_err_count
  );
endinterface

// File: rtl/receive.sv
// PCS receive state machine: turns decoded /I/ /S/ /D/ /T/ /R/ code groups into
// registered GMII RXD/RX_DV/RX_ER and keeps a saturating receive-error count.
module receive #(
  parameter int ERR_CNT_W = 8
) (
  input  logic     GTX_CLK,
  input  logic     mr_main_reset,
  receive_if.slave bus
);

  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic [7:0] K_START  = 8'hFB;
  localparam logic [7:0] K_TERM   = 8'hFD;
  localparam logic [7:0] K_CEXT   = 8'hF7;
  localparam logic [7:0] D5_6     = 8'hC5;
  localparam logic [7:0] D16_2    = 8'h50;
  localparam logic [7:0] PREAMBLE = 8'h55;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [7:0] {
    LINK_FAILED     = 8'b0000_0001,
    WAIT_FOR_K      = 8'b0000_0010,
    RX_K            = 8'b0000_0100,
    IDLE_D          = 8'b0000_1000,
    START_OF_PACKET = 8'b0001_0000,
    RECEIVE         = 8'b0010_0000,
    TRI             = 8'b0100_0000,
    TRR             = 8'b1000_0000
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_rxd;
  logic                 r_rx_dv;
  logic                 r_rx_er;
  logic                 r_receiving;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic [7:0] w_rxd;
  logic       w_rx_dv;
  logic       w_rx_er;
  logic       w_receiving;
  logic       w_err;

  logic w_kgrp;
  logic w_data;
  logic w_comma;
  logic w_start;
  logic w_term;
  logic w_cext;
  logic w_idle_d;

  assign w_kgrp   = bus.rx_is_k & bus.rx_cg_valid;
  assign w_data   = ~bus.rx_is_k & bus.rx_cg_valid;
  assign w_comma  = w_kgrp & (bus.rx_octet == K28_5);
  assign w_start  = w_kgrp & (bus.rx_octet == K_START);
  assign w_term   = w_kgrp & (bus.rx_octet == K_TERM);
  assign w_cext   = w_kgrp & (bus.rx_octet == K_CEXT);
  assign w_idle_d = w_data & ((bus.rx_octet == D5_6) || (bus.rx_octet == D16_2));

  // State register and registered GMII outputs
  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      r_state     <= LINK_FAILED;
      r_rxd       <= 8'h00;
      r_rx_dv     <= 1'b0;
      r_rx_er     <= 1'b0;
      r_receiving <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rxd       <= w_rxd;
      r_rx_dv     <= w_rx_dv;
      r_rx_er     <= w_rx_er;
      r_receiving <= w_receiving;
    end
  end

  // Next state and next output values; loss of sync overrides every state
  always_comb begin
    w_next      = r_state;
    w_rxd       = 8'h00;
    w_rx_dv     = 1'b0;
    w_rx_er     = 1'b0;
    w_receiving = 1'b0;
    w_err       = 1'b0;
    if (!bus.sync_status) begin
      w_next = LINK_FAILED;
      if (r_receiving) begin
        w_rx_dv = 1'b1;
        w_rx_er = 1'b1;
        w_err   = 1'b1;
      end else begin
        w_rx_dv = 1'b0;
      end
    end else begin
      case (r_state)
        LINK_FAILED: w_next = WAIT_FOR_K;
        WAIT_FOR_K: begin
          if (w_comma) w_next = RX_K;
          else         w_next = WAIT_FOR_K;
        end
        RX_K: begin
          if (w_idle_d) begin
            w_next = IDLE_D;
          end else begin
            w_next = WAIT_FOR_K;
            w_err  = 1'b1;
          end
        end
        IDLE_D: begin
          if (w_comma) begin
            w_next = RX_K;
          end else if (w_start) begin
            w_next      = START_OF_PACKET;
            w_rxd       = PREAMBLE;
            w_rx_dv     = 1'b1;
            w_receiving = 1'b1;
          end else begin
            w_next = WAIT_FOR_K;
            w_err  = 1'b1;
          end
        end
        START_OF_PACKET, RECEIVE: begin
          w_receiving = 1'b1;
          if (w_data) begin
            w_next  = RECEIVE;
            w_rxd   = bus.rx_octet;
            w_rx_dv = 1'b1;
          end else if (w_term) begin
            w_next = TRI;
          end else begin
            // Early end (comma) resynchronises; any other bad group stays in the packet
            w_next  = w_comma ? RX_K : RECEIVE;
            w_rx_dv = 1'b1;
            w_rx_er = 1'b1;
            w_err   = 1'b1;
          end
        end
        TRI: begin
          if (w_cext) begin
            w_next = TRR;
          end else begin
            w_next = WAIT_FOR_K;
            w_err  = 1'b1;
          end
        end
        TRR: begin
          if (w_cext) begin
            w_next = TRR;
          end else if (w_comma) begin
            w_next = RX_K;
          end else begin
            w_next = WAIT_FOR_K;
            w_err  = 1'b1;
          end
        end
        default: w_next = LINK_FAILED;
      endcase
    end
  end

  // Saturating error counter, one increment per cycle at most
  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      r_err_count <= {ERR_CNT_W{1'b0}};
    end else if (w_err && (r_err_count != CNT_MAX)) begin
      r_err_count <= r_err_count + CNT_ONE;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign bus.RXD          = r_rxd;
  assign bus.RX_DV        = r_rx_dv;
  assign bus.RX_ER        = r_rx_er;
  assign bus.receiving    = r_receiving;
  assign bus.rx_err_count = r_err_count;

endmodule

// File: tb/tb_receive.sv
// Scoreboard bench for receive: directed code-group vectors push expected GMII outputs,
// a negedge monitor pops and compares. A second instance with a 2-bit counter checks saturation.
module tb_receive;

  logic clk;
  logic rst_n;

  receive_if #(.ERR_CNT_W(8)) if8 ();
  receive_if #(.ERR_CNT_W(2)) if2 ();

  receive #(.ERR_CNT_W(8)) dut8 (.GTX_CLK(clk), .mr_main_reset(rst_n), .bus(if8));
  receive #(.ERR_CNT_W(2)) dut2 (.GTX_CLK(clk), .mr_main_reset(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {RX_DV, RX_ER, receiving}
  localparam logic [2:0] F_IDLE  = 3'b000;
  localparam logic [2:0] F_DATA  = 3'b101;
  localparam logic [2:0] F_ERR   = 3'b111;
  localparam logic [2:0] F_END   = 3'b001;
  localparam logic [2:0] F_TRUNC = 3'b110;

  typedef struct {
    int         cyc;
    logic [7:0] rxd;
    logic [2:0] fl;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops every entry due in the current cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("stamp", cyc, e.cyc);
      chk("rxd", int'(if8.RXD), int'(e.rxd));
      chk("dv_er_rcv", int'({if8.RX_DV, if8.RX_ER, if8.receiving}), int'(e.fl));
      chk("err_count", int'(if8.rx_err_count), e.cnt);
      chk("rxd_w2", int'(if2.RXD), int'(e.rxd));
      chk("err_count_sat", int'(if2.rx_err_count), (e.cnt > 3) ? 3 : e.cnt);
    end
  end

  task automatic send(input logic s, input logic k, input logic v, input logic [7:0] o,
                      input logic [7:0] xd, input logic [2:0] xf, input int xc);
    exp_t e;
    @(posedge clk);
    #1;
    if8.sync_status = s; if8.rx_is_k = k; if8.rx_cg_valid = v; if8.rx_octet = o;
    if2.sync_status = s; if2.rx_is_k = k; if2.rx_cg_valid = v; if2.rx_octet = o;
    e.cyc = cyc + 1;
    e.rxd = xd;
    e.fl  = xf;
    e.cnt = xc;
    q.push_back(e);
  endtask

  task automatic kk(input logic [7:0] o, input logic [7:0] xd, input logic [2:0] xf, input int xc);
    send(1'b1, 1'b1, 1'b1, o, xd, xf, xc);
  endtask

  task automatic dd(input logic [7:0] o, input logic [7:0] xd, input logic [2:0] xf, input int xc);
    send(1'b1, 1'b0, 1'b1, o, xd, xf, xc);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rxd"}, int'(if8.RXD), 0);
    chk({tag, "_flags"}, int'({if8.RX_DV, if8.RX_ER, if8.receiving}), 0);
    chk({tag, "_cnt"}, int'(if8.rx_err_count), 0);
    chk({tag, "_cnt_w2"}, int'(if2.rx_err_count), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    if8.sync_status = 1'b0; if8.rx_is_k = 1'b0; if8.rx_cg_valid = 1'b1; if8.rx_octet = 8'h00;
    if2.sync_status = 1'b0; if2.rx_is_k = 1'b0; if2.rx_cg_valid = 1'b1; if2.rx_octet = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle lock, then a short packet
    kk(8'hBC, 8'h00, F_IDLE, 0);
    dd(8'h50, 8'h00, F_IDLE, 0);
    for (int i = 0; i < 3; i++) begin
      kk(8'hBC, 8'h00, F_IDLE, 0);
      dd(8'h50, 8'h00, F_IDLE, 0);
    end
    kk(8'hFB, 8'h55, F_DATA, 0);
    dd(8'h11, 8'h11, F_DATA, 0);
    dd(8'h22, 8'h22, F_DATA, 0);
    dd(8'h33, 8'h33, F_DATA, 0);
    kk(8'hFD, 8'h00, F_END, 0);
    kk(8'hF7, 8'h00, F_IDLE, 0);
    kk(8'hBC, 8'h00, F_IDLE, 0);
    dd(8'h50, 8'h00, F_IDLE, 0);

    // Mid-packet invalid group
    kk(8'hFB, 8'h55, F_DATA, 0);
    dd(8'hAA, 8'hAA, F_DATA, 0);
    send(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, F_ERR, 1);
    dd(8'hBB, 8'hBB, F_DATA, 1);
    kk(8'hFD, 8'h00, F_END, 1);
    kk(8'hF7, 8'h00, F_IDLE, 1);
    kk(8'hBC, 8'h00, F_IDLE, 1);
    dd(8'hC5, 8'h00, F_IDLE, 1);

    // Early end, then a new packet is accepted
    kk(8'hFB, 8'h55, F_DATA, 1);
    dd(8'h01, 8'h01, F_DATA, 1);
    kk(8'hBC, 8'h00, F_ERR, 2);
    dd(8'hC5, 8'h00, F_IDLE, 2);
    kk(8'hFB, 8'h55, F_DATA, 2);
    dd(8'h77, 8'h77, F_DATA, 2);

    // Bad end delimiter: /S/ ignored until K28.5 D /S/
    kk(8'hFD, 8'h00, F_END, 2);
    dd(8'h00, 8'h00, F_IDLE, 3);
    kk(8'hFB, 8'h00, F_IDLE, 3);
    dd(8'h44, 8'h00, F_IDLE, 3);
    kk(8'hBC, 8'h00, F_IDLE, 3);
    dd(8'h50, 8'h00, F_IDLE, 3);
    kk(8'hFB, 8'h55, F_DATA, 3);
    dd(8'h66, 8'h66, F_DATA, 3);

    // Other K inside a packet stays in the packet
    kk(8'hFE, 8'h00, F_ERR, 4);
    dd(8'h67, 8'h67, F_DATA, 4);

    // Sync loss mid-packet: one truncation cycle, then defaults
    send(1'b0, 1'b0, 1'b1, 8'h99, 8'h00, F_TRUNC, 5);
    send(1'b0, 1'b0, 1'b1, 8'h99, 8'h00, F_IDLE, 5);
    kk(8'hBC, 8'h00, F_IDLE, 5);
    kk(8'hBC, 8'h00, F_IDLE, 5);
    dd(8'h50, 8'h00, F_IDLE, 5);
    dd(8'h12, 8'h00, F_IDLE, 6);
    kk(8'hBC, 8'h00, F_IDLE, 6);
    dd(8'hC5, 8'h00, F_IDLE, 6);
    kk(8'hFB, 8'h55, F_DATA, 6);
    dd(8'h5A, 8'h5A, F_DATA, 6);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);

    // Asynchronous reset between edges while a packet is in progress
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
